// File: rtl/conv_mac_ctrl.sv
// Compute stage of the 1-D convolution engine: reads the X and F memories,
// accumulates valid-mode outputs y[n] = sum x[n+k]*f[k], streams them out.
module conv_mac_ctrl #(
  parameter int DATA_N    = 8,
  parameter int LG_DATA_N = 3,
  parameter int FILT_N    = 4,
  parameter int LG_FILT_N = 2,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_x,
  input  logic                    done_f,
  output logic                    mem_wr_state,
  output logic                    mem_wr_done,
  output logic [LG_DATA_N-1:0]    rd_addr_x,
  input  logic [IN_W-1:0]         rd_data_x,
  output logic [LG_FILT_N-1:0]    rd_addr_f,
  input  logic [IN_W-1:0]         rd_data_f,
  output logic signed [OUT_W-1:0] m_data_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [LG_DATA_N-1:0]    n;
  logic [LG_FILT_N-1:0]    k;
  logic                    issue_done;
  logic                    acc_en;
  logic signed [OUT_W-1:0] acc;
  logic signed [2*IN_W-1:0] prod;

  logic last_tap;
  logic last_out;
  logic issue;

  assign last_tap = (k == LG_FILT_N'(FILT_N - 1));
  assign last_out = (n == LG_DATA_N'(DATA_N - FILT_N));
  assign issue    = (state == MAC) && !issue_done;
  assign prod     = $signed(rd_data_x) * $signed(rd_data_f);
  assign m_data_y = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    mem_wr_state = 1'b0;
    mem_wr_done  = 1'b0;
    m_valid_y    = 1'b0;
    rd_addr_x    = '0;
    rd_addr_f    = '0;
    case (state)
      LOAD: begin
        mem_wr_state = 1'b1;
        if (done_x && done_f) state_next = MAC;
      end
      MAC: begin
        rd_addr_x = n + LG_DATA_N'(k);
        rd_addr_f = k;
        // issue_done marks the drain cycle, where the last tap is accumulated
        if (issue_done) state_next = OUT;
      end
      OUT: begin
        m_valid_y = 1'b1;
        if (m_ready_y) state_next = last_out ? DONE : MAC;
      end
      DONE: begin
        mem_wr_done = 1'b1;
        state_next  = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n          <= '0;
      k          <= '0;
      issue_done <= 1'b0;
      acc_en     <= 1'b0;
      acc        <= '0;
    end else begin
      acc_en <= issue;
      case (state)
        LOAD: begin
          if (done_x && done_f) begin
            n          <= '0;
            k          <= '0;
            issue_done <= 1'b0;
            acc        <= '0;
          end
        end
        MAC: begin
          if (acc_en)
            acc <= acc + {{(OUT_W - 2*IN_W){prod[2*IN_W-1]}}, prod};
          if (!issue_done) begin
            if (last_tap) issue_done <= 1'b1;
            else          k          <= k + 1'b1;
          end
        end
        OUT: begin
          if (m_ready_y && !last_out) begin
            n          <= n + 1'b1;
            k          <= '0;
            issue_done <= 1'b0;
            acc        <= '0;
          end
        end
        DONE: begin
          n <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl: behavioural X/F memories with 1-cycle read
// latency and a queue of expected outputs computed from the loaded data.
module tb_conv_mac_ctrl;

  logic              clk;
  logic              reset;
  logic              done_x;
  logic              done_f;
  logic              mem_wr_state;
  logic              mem_wr_done;
  logic [2:0]        rd_addr_x;
  logic [7:0]        rd_data_x;
  logic [1:0]        rd_addr_f;
  logic [7:0]        rd_data_f;
  logic signed [17:0] m_data_y;
  logic              m_valid_y;
  logic              m_ready_y;

  logic signed [7:0] xmem [8];
  logic signed [7:0] fmem [4];

  int n_asserts = 0;
  int n_fail    = 0;
  int hs_count  = 0;
  int exp_q [$];

  conv_mac_ctrl #(
    .DATA_N(8), .LG_DATA_N(3), .FILT_N(4), .LG_FILT_N(2), .IN_W(8), .OUT_W(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .done_x(done_x),
    .done_f(done_f),
    .mem_wr_state(mem_wr_state),
    .mem_wr_done(mem_wr_done),
    .rd_addr_x(rd_addr_x),
    .rd_data_x(rd_data_x),
    .rd_addr_f(rd_addr_f),
    .rd_data_f(rd_data_f),
    .m_data_y(m_data_y),
    .m_valid_y(m_valid_y),
    .m_ready_y(m_ready_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rd_data_x <= xmem[rd_addr_x];
    rd_data_f <= fmem[rd_addr_f];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},    32'(m_valid_y),    0);
    chk({tag, "_data"},     32'(m_data_y),     0);
    chk({tag, "_wr_state"}, 32'(mem_wr_state), 1);
    chk({tag, "_wr_done"},  32'(mem_wr_done),  0);
    chk({tag, "_addr_x"},   32'(rd_addr_x),    0);
    chk({tag, "_addr_f"},   32'(rd_addr_f),    0);
  endtask

  task automatic fill_x_ramp();
    for (int i = 0; i < 8; i++) xmem[i] = 8'(i + 1);
  endtask

  task automatic fill_x_const(input logic signed [7:0] v);
    for (int i = 0; i < 8; i++) xmem[i] = v;
  endtask

  task automatic set_f(input logic signed [7:0] a, b, c, d);
    fmem[0] = a; fmem[1] = b; fmem[2] = c; fmem[3] = d;
  endtask

  task automatic push_expected();
    for (int n = 0; n <= 4; n++) begin
      int s = 0;
      for (int k = 0; k < 4; k++) s += int'(xmem[n + k]) * int'(fmem[k]);
      exp_q.push_back(s);
    end
  endtask

  // Called on the negedge where the last of done_x/done_f was raised.
  task automatic wait_first();
    int cnt;
    step(1);
    done_x = 1'b0;
    done_f = 1'b0;
    chk("wr_state_in_mac", 32'(mem_wr_state), 0);
    cnt = 1;
    while (!m_valid_y && cnt < 40) begin
      step(1);
      cnt++;
    end
    chk("first_latency", cnt, 6);
  endtask

  task automatic start_frame();
    push_expected();
    done_x = 1'b1;
    done_f = 1'b1;
    wait_first();
  endtask

  task automatic collect(input int num, input int stall_idx, input int stall_len);
    int cnt;
    int e;
    for (int i = 0; i < num; i++) begin
      if (i == stall_idx) m_ready_y = 1'b0;
      cnt = 0;
      while (!m_valid_y && cnt < 40) begin
        step(1);
        cnt++;
      end
      chk("valid_seen", 32'(m_valid_y), 1);
      if (i > 0) chk("period", cnt + 1, 6);
      if (exp_q.size() == 0) chk("scoreboard_nonempty", exp_q.size(), 1);
      e = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_valid", 32'(m_valid_y), 1);
          chk("stall_data", 32'(m_data_y), e);
          step(1);
        end
        m_ready_y = 1'b1;
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      chk("y", 32'(m_data_y), e);
      chk("wr_state_in_out", 32'(mem_wr_state), 0);
      hs_count++;
      step(1);
      chk("valid_pulse", 32'(m_valid_y), 0);
    end
  endtask

  task automatic done_tail();
    chk("wr_done_pulse", 32'(mem_wr_done), 1);
    chk("wr_state_in_done", 32'(mem_wr_state), 0);
    step(1);
    chk("wr_done_low", 32'(mem_wr_done), 0);
    chk("wr_state_back", 32'(mem_wr_state), 1);
  endtask

  initial begin
    reset     = 1'b1;
    done_x    = 1'b0;
    done_f    = 1'b0;
    m_ready_y = 1'b1;
    fill_x_ramp();
    set_f(1, 1, 1, 1);
    step(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    step(1);

    // Frame: x=1..8, f=1 -> 10,14,18,22,26
    start_frame();
    collect(5, -1, 0);
    done_tail();

    // done_x alone must not start; extremes -128 * -128 -> 65536
    fill_x_const(-8'sd128);
    set_f(-8'sd128, -8'sd128, -8'sd128, -8'sd128);
    push_expected();
    done_x = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("hold_valid", 32'(m_valid_y), 0);
      chk("hold_wr_state", 32'(mem_wr_state), 1);
    end
    done_f = 1'b1;
    wait_first();
    collect(5, -1, 0);
    done_tail();

    // -128 * 127 -> -65024
    set_f(8'sd127, 8'sd127, 8'sd127, 8'sd127);
    start_frame();
    collect(5, -1, 0);
    done_tail();

    // Backpressure on output 2 for 7 cycles
    fill_x_ramp();
    set_f(1, 1, 1, 1);
    hs_count = 0;
    start_frame();
    collect(5, 2, 7);
    chk("handshakes", hs_count, 5);
    chk("scoreboard_drained", exp_q.size(), 0);
    done_tail();

    // Reset during the MAC of output 3
    start_frame();
    collect(3, -1, 0);
    step(2);
    chk("mac_addr_x", 32'(rd_addr_x), 5);
    chk("mac_addr_f", 32'(rd_addr_f), 2);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    step(1);
    reset = 1'b0;
    step(1);

    // Reload x=1..8, f=1,2,3,4 -> 30,40,50,60,70
    set_f(1, 2, 3, 4);
    start_frame();
    collect(5, -1, 0);
    done_tail();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mac_ctrl.md
# conv_mac_ctrl

Downstream compute stage of the 1-D convolution engine. It waits until the X-vector and filter memories have been loaded by their write-side control units, then reads both memories and computes each valid-mode output y[n] = Σ x[n+k]·f[k] with a multi-cycle multiply-accumulate. Results are delivered over a valid/ready stream. After the last output it pulses a write-done signal so the memories can be reloaded. It owns the `mem_wr_state` / `mem_wr_done` signals consumed by the X and F write controllers.

## Interface
Parameters:
- `DATA_N`, 8: X-vector length.
- `LG_DATA_N`, 3: log2(DATA_N).
- `FILT_N`, 4: filter taps; must satisfy FILT_N ≤ DATA_N.
- `LG_FILT_N`, 2: log2(FILT_N).
- `IN_W`, 8: signed width of x and f samples.
- `OUT_W`, 18: signed result width; equals 2·IN_W + LG_FILT_N.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `done_x`  in  1: X memory fully written (level).
- `done_f`  in  1: F memory fully written (level).
- `mem_wr_state`  out  1: high while memories may be written (LOAD state).
- `mem_wr_done`  out  1: one-cycle pulse after the final output handshake.
- `rd_addr_x`  out  LG_DATA_N: X memory read address.
- `rd_data_x`  in  IN_W: X read data, valid 1 cycle after the address.
- `rd_addr_f`  out  LG_FILT_N: F memory read address.
- `rd_data_f`  in  IN_W: F read data, valid 1 cycle after the address.
- `m_data_y`  out  OUT_W: signed convolution result.
- `m_valid_y`  out  1: result valid.
- `m_ready_y`  in  1: consumer ready.

## Operation
- Counters:
  - `n` counts outputs, 0..DATA_N−FILT_N.
  - `k` counts taps, 0..FILT_N−1.
  - A 1-bit `acc_en` is the issue flag delayed by one cycle, to match memory latency.
- FSM states: LOAD, MAC, OUT, DONE.
- LOAD:
  - `mem_wr_state`=1.
  - On a cycle with `done_x` & `done_f` both 1, go to MAC with n=0, k=0, accumulator cleared.
  - If only one of them is high, stay in LOAD.
- MAC:
  - `rd_addr_x`=n+k, `rd_addr_f`=k; k increments each cycle.
  - One cycle later, acc += signed(rd_data_x)·signed(rd_data_f), full width with no truncation. Sign-extend the 2·IN_W product to OUT_W.
  - After the tap issued at k=FILT_N−1 has been accumulated, go to OUT.
- OUT:
  - `m_data_y`=acc (registered) and `m_valid_y`=1.
  - `m_data_y` stays stable until the handshake (`m_valid_y` & `m_ready_y`).
  - On handshake:
    - If n=DATA_N−FILT_N, go to DONE.
    - Otherwise n++, k=0, clear acc, go to MAC.
- DONE:
  - `mem_wr_done`=1 for exactly one cycle.
  - Then go to LOAD with n=0.
- Outside MAC, read addresses are 0.
- Overflow is impossible by construction of OUT_W; no saturation logic.

## Timing
- Reset (async, immediate), from any state including mid-MAC or mid-OUT:
  - State goes to LOAD; n, k, acc, `acc_en` go to 0.
  - `mem_wr_state`=1; `mem_wr_done`=0; `m_valid_y`=0; `m_data_y`=0; `rd_addr_x`=0; `rd_addr_f`=0.
  - Any in-progress output is discarded.
- LOAD→MAC takes 1 edge after the cycle in which `done_x`&`done_f` is seen.
- MAC occupies FILT_N+1 cycles: FILT_N issue cycles plus 1 drain cycle. `m_valid_y` rises on the following edge.
  - Default parameters: 5 MAC cycles per output.
- Handshake:
  - `m_valid_y` never depends combinationally on `m_ready_y`.
  - `m_ready_y` already high when `m_valid_y` rises completes the transfer in that same cycle: OUT lasts 1 cycle.
  - `m_ready_y` low holds the OUT state indefinitely, with data stable.
- Throughput with `m_ready_y` held high: one output per FILT_N+2 cycles.
- `mem_wr_done` pulses the cycle after the last handshake. `mem_wr_state` rises the cycle after that.
- `mem_wr_state` is 0 throughout MAC, OUT and DONE.
- `done_x`/`done_f` changes outside LOAD are ignored.

## Test plan
- Load x=1..8 and f=1,1,1,1, hold `m_ready_y`=1 → outputs 10,14,18,22,26 are observed.
  - Each `m_valid_y` pulse is 1 cycle, with a 6-cycle period.
  - A single `mem_wr_done` pulse follows, then `mem_wr_state`=1.
- Assert `done_x`=1 with `done_f`=0 for 20 cycles → remains in LOAD with `m_valid_y`=0 and `mem_wr_state`=1.
  - Raise `done_f` → first `m_valid_y` appears 6 cycles later.
- Sign and width extremes:
  - x all −128 with f all −128 → every y=65536.
  - x all −128 with f all 127 → every y=−65024.
- Backpressure: `m_ready_y` low for 7 cycles on output 2 → `m_valid_y` stays high and `m_data_y`=18 stays stable. No output is lost or duplicated; total handshakes = 5.
- Reset asserted during the MAC of output 3 → all outputs return to their reset values immediately.
  - After reload with x=1..8, f=1,2,3,4, the sequence restarts at y0=30, then 40,50,60,70.
- Back-to-back frames: after `mem_wr_done`, reload with new data → the second frame's 5 outputs are correct and independent of the first.
